out_bit_packer: RTL and testbench

OUT_BIT_PACKER -- requirements
Module: out_bit_packer

---
 rtl/out_packer_pkg.sv | 12 +
 rtl/out_word_fifo.sv | 80 ++++++++
 rtl/out_bit_packer.sv | 104 ++++++++++
 tb/tb_out_bit_packer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_packer_pkg.sv
// Shared constants and FSM state type for the output bit packer.
package out_packer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DROP_W        = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

endpackage : out_packer_pkg

// File: rtl/out_word_fifo.sv
// Two-entry word buffer; entry 0 is the head and drives dout directly.
// Optional macro OUT_PACKER_PARITY_EN adds a registered parity of the head word.
module out_word_fifo
  import out_packer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
`ifdef OUT_PACKER_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] mem0_q, mem1_q, mem0_d, mem1_d;
  logic             v0_q, v1_q, v0_d, v1_d;
  logic             pop_ok;

  assign pop_ok = pop & v0_q;

  // Next buffer contents: pop shifts entry 1 to the head, then push fills the first free slot.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    if (pop_ok) begin
      mem0_d = mem1_q;
      v0_d   = v1_q;
      v1_d   = 1'b0;
    end
    if (push) begin
      if (!v0_d) begin
        mem0_d = din;
        v0_d   = 1'b1;
      end else if (!v1_d) begin
        mem1_d = din;
        v1_d   = 1'b1;
      end
    end
  end

  // Buffer storage and occupancy flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem0_q <= '0;
      mem1_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
    end
  end

`ifdef OUT_PACKER_PARITY_EN
  // Parity tracks the head entry so it lines up with dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else begin
      parity <= ^mem0_d;
    end
  end
`endif

  assign dout  = mem0_q;
  assign full  = v1_q;
  assign empty = ~v0_q;

endmodule : out_word_fifo

// File: rtl/out_bit_packer.sv
// Packs a serial bit stream LSB-first into WIDTH-bit words and buffers them
// in a two-entry FIFO; words completing into a full buffer are dropped and counted.
// Optional macro OUT_PACKER_PARITY_EN adds the word_parity output.
module out_bit_packer
  import out_packer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WIDTH-1:0]  word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
`ifdef OUT_PACKER_PARITY_EN
  ,
  output logic              word_parity
`endif
);

  localparam int unsigned      CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  pack_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] word_c;
  logic             word_done, pop, push, drop;
  logic             fifo_full, fifo_empty;

  // A word completes when the last bit position is accepted while filling.
  assign word_done = bit_valid && (state_q == FILL) && (cnt_q == LAST);
  assign word_c    = {bit_in, shreg_q[WIDTH-1:1]};
  assign pop       = word_valid & word_ready;
  assign push      = word_done & (~fifo_full | pop);
  assign drop      = word_done & fifo_full & ~pop;

  // Next state: any accepted bit leaves IDLE, the final bit returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: if (cnt_q == LAST) state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Right shift so the first bit of a word ends up in bit 0 once WIDTH bits are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (bit_valid) begin
      cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      shreg_q <= {bit_in, shreg_q[WIDTH-1:1]};
    end
  end

  // Sticky overflow and saturating count of dropped words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  out_word_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (word_c),
    .pop   (pop),
    .dout  (word_data),
    .full  (fifo_full),
    .empty (fifo_empty)
`ifdef OUT_PACKER_PARITY_EN
    ,
    .parity(word_parity)
`endif
  );

  assign word_valid = ~fifo_empty;

endmodule : out_bit_packer

// File: tb/tb_out_bit_packer.sv
// Bench for out_bit_packer: queue-based reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_out_bit_packer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         bit_in;
  logic         bit_valid;
  logic         word_ready;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         overflow;
  logic [7:0]   drop_count;
`ifdef OUT_PACKER_PARITY_EN
  logic         word_parity;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: accepted words waiting for the consumer.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_acc;
  logic [W-1:0] m_word;
  int           m_nbits;
  logic         m_ovf;
  int           m_drops;
  logic         m_done;

  out_bit_packer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .drop_count (drop_count)
`ifdef OUT_PACKER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect bits into a word; consumer pops the head, then a finished word
  // enters the buffer if there is room after the pop, else it is dropped.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_acc   = '0;
      m_nbits = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_done = 1'b0;
      if (bit_valid) begin
        m_acc[m_nbits] = bit_in;
        m_nbits++;
        if (m_nbits == W) begin
          m_done  = 1'b1;
          m_word  = m_acc;
          m_acc   = '0;
          m_nbits = 0;
        end
      end
      if (word_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_done) begin
        if (m_q.size() < 2) m_q.push_back(m_word);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  // Per-cycle compare, settled after the falling edge.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("rst_valid", word_valid, 0);
      chk("rst_data", word_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_count", drop_count, 0);
`ifdef OUT_PACKER_PARITY_EN
      chk("rst_parity", word_parity, 0);
`endif
    end else begin
      chk("valid", word_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("data", word_data, m_q[0]);
`ifdef OUT_PACKER_PARITY_EN
        chk("parity", word_parity, ^m_q[0]);
`endif
      end
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drops[7:0]);
    end
  end

  task automatic drive(input logic v, input logic b, input logic r);
    bit_valid  = v;
    bit_in     = b;
    word_ready = r;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r, input logic r_last);
    for (int i = 0; i < W; i++) drive(1'b1, w[i], (i == W - 1) ? r_last : r);
  endtask

  task automatic do_reset();
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    word_ready = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] seq;
    reset      = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    word_ready = 1'b0;
    do_reset();
    chk("init_valid", word_valid, 0);
    chk("init_drop_count", drop_count, 0);

    // Bits 1,0,1,1,0,0,1,0 with consumer ready: one-cycle 8'h4D.
    seq = 8'h4D;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, seq[i], 1'b1);
      if (i < W - 1) chk("s1_early_valid", word_valid, 0);
    end
    chk("s1_valid", word_valid, 1);
    chk("s1_data", word_data, 8'h4D);
`ifdef OUT_PACKER_PARITY_EN
    chk("s1_parity", word_parity, 0);
`endif
    drive(1'b0, 1'b0, 1'b1);
    chk("s1_once", word_valid, 0);

`ifdef OUT_PACKER_PARITY_EN
    send_word(8'h4C, 1'b1, 1'b1);
    chk("par_data", word_data, 8'h4C);
    chk("par_odd", word_parity, 1);
    drive(1'b0, 1'b0, 1'b1);
`endif

    // Full buffer with stalled consumer: third word dropped.
    do_reset();
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h00, 1'b0, 1'b0);
    send_word(8'hAA, 1'b0, 1'b0);
    chk("s2_overflow", overflow, 1);
    chk("s2_drop_count", drop_count, 1);
    chk("s2_head", word_data, 8'hFF);
    drive(1'b0, 1'b0, 1'b1);
    chk("s2_second", word_data, 8'h00);
    chk("s2_second_valid", word_valid, 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("s2_empty", word_valid, 0);

    // Alternate idle cycles carry garbage on bit_in; it must be ignored.
    do_reset();
    seq = 8'h4D;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, seq[i], 1'b1);
      if (i < W - 1) drive(1'b0, ~seq[i], 1'b1);
    end
    chk("s3_data", word_data, 8'h4D);
    chk("s3_valid", word_valid, 1);
    drive(1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial bits.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
    do_reset();
    send_word(8'h0F, 1'b1, 1'b1);
    chk("s4_data", word_data, 8'h0F);
    chk("s4_drop_count", drop_count, 0);
    drive(1'b0, 1'b0, 1'b1);

    // Pop coinciding with a push into a full buffer: nothing dropped.
    do_reset();
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h00, 1'b0, 1'b0);
    chk("s5_head0", word_data, 8'hFF);
    send_word(8'h5A, 1'b0, 1'b1);
    chk("s5_overflow", overflow, 0);
    chk("s5_drop_count", drop_count, 0);
    chk("s5_head1", word_data, 8'h00);
    drive(1'b0, 1'b0, 1'b1);
    chk("s5_head2", word_data, 8'h5A);
    drive(1'b0, 1'b0, 1'b1);
    chk("s5_empty", word_valid, 0);

    // Long stall: drop counter saturates.
    do_reset();
    for (int k = 0; k < 262; k++) send_word(W'($urandom), 1'b0, 1'b0);
    chk("sat_drop_count", drop_count, 255);
    chk("sat_overflow", overflow, 1);

    // Random traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_out_bit_packer
